sseg_capture: RTL and testbench

- Receive-side counterpart to the team's multiplexed seven-segment display drivers.
- Samples the active-low anode and cathode bus that a driver presents to the display.
- Qualifies each anode slot with a stability filter, then decodes the segment pattern back to a 4-bit hex value held per digit.
- Used as an on-chip monitor and a self-check target in display testbenches and loopback builds.

---
 rtl/sseg_capture_if.sv | 24 ++
 rtl/sseg_capture.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sseg_capture.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_capture_if.sv
// Seven-segment display bus plus the per-digit results recovered by sseg_capture.
// master: the display driver / environment side; slave: the capture monitor.
interface sseg_capture_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sseg;
  logic                    dp;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   err;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic                    frame_done;

  modport master (
    output an, sseg, dp,
    input  digits, valid, err, dp_out, frame_done
  );

  modport slave (
    input  an, sseg, dp,
    output digits, valid, err, dp_out, frame_done
  );
endinterface

// File: rtl/sseg_capture.sv
// Recovers per-digit hex values from a multiplexed active-low seven-segment bus.
// Define SSEG_CAPTURE_DP_EN to capture the decimal point and include it in the stability check.
module sseg_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  sseg_capture_if.slave bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StHold
  } state_e;

  // Returns {legal, value}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Registered copies of the display bus
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            sseg_q;

  // Reference sample being qualified
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       ref_idx_q, ref_idx_d;
  logic [6:0]            ref_sseg_q, ref_sseg_d;

  // Captured results
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0] an_low;
  logic [IdxW-1:0]       slot_idx;
  logic                  slot_legal;
  logic                  sample_match;
  logic                  capture;
  logic                  mismatch;
  logic                  reload;
  logic                  cap_legal;
  logic [3:0]            cap_val;
  logic [NUM_DIGITS-1:0] seen_nxt;

`ifdef SSEG_CAPTURE_DP_EN
  logic                  dp_q;
  logic                  ref_dp_q, ref_dp_d;
  logic [NUM_DIGITS-1:0] dp_out_q, dp_out_d;
`else
  // The decimal point plays no part when the feature is compiled out.
  logic                  unused_dp;
  assign unused_dp = bus.dp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '1;
      sseg_q <= '1;
`ifdef SSEG_CAPTURE_DP_EN
      dp_q   <= 1'b1;
`endif
    end else begin
      an_q   <= bus.an;
      sseg_q <= bus.sseg;
`ifdef SSEG_CAPTURE_DP_EN
      dp_q   <= bus.dp;
`endif
    end
  end

  // A slot exists only when exactly one anode is pulled low.
  always_comb begin
    an_low     = ~an_q;
    slot_legal = $onehot(an_low);
    slot_idx   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) slot_idx = IdxW'(i);
    end
  end

  assign sample_match = slot_legal && (slot_idx == ref_idx_q) && (sseg_q == ref_sseg_q)
`ifdef SSEG_CAPTURE_DP_EN
                        && (dp_q == ref_dp_q)
`endif
                        ;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_idx_d  = ref_idx_q;
    ref_sseg_d = ref_sseg_q;
`ifdef SSEG_CAPTURE_DP_EN
    ref_dp_d   = ref_dp_q;
`endif
    capture    = 1'b0;
    mismatch   = 1'b0;
    reload     = 1'b0;

    case (state_q)
      StIdle: begin
        reload = slot_legal;
      end
      StTrack: begin
        // The capture depends only on the samples already counted; the current
        // sample decides whether we hold or start qualifying a new slot.
        if (cnt_q == CntMax) begin
          capture = 1'b1;
          if (sample_match) state_d = StHold;
          else              mismatch = 1'b1;
        end else if (sample_match) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          mismatch = 1'b1;
        end
      end
      StHold: begin
        mismatch = !sample_match;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (mismatch) begin
      if (slot_legal) begin
        reload = 1'b1;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end

    if (reload) begin
      ref_idx_d  = slot_idx;
      ref_sseg_d = sseg_q;
`ifdef SSEG_CAPTURE_DP_EN
      ref_dp_d   = dp_q;
`endif
      cnt_d      = CntOne;
      state_d    = StTrack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ref_idx_q  <= '0;
      ref_sseg_q <= '1;
`ifdef SSEG_CAPTURE_DP_EN
      ref_dp_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_idx_q  <= ref_idx_d;
      ref_sseg_q <= ref_sseg_d;
`ifdef SSEG_CAPTURE_DP_EN
      ref_dp_q   <= ref_dp_d;
`endif
    end
  end

  assign {cap_legal, cap_val} = seg_decode(ref_sseg_q);

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    seen_nxt     = seen_q;
    frame_done_d = 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
    dp_out_d     = dp_out_q;
`endif

    if (capture) begin
      if (cap_legal) begin
        digits_d[{ref_idx_q, 2'b00} +: 4] = cap_val;
        valid_d[ref_idx_q]                = 1'b1;
        err_d[ref_idx_q]                  = 1'b0;
      end else begin
        valid_d[ref_idx_q] = 1'b0;
        err_d[ref_idx_q]   = 1'b1;
      end
`ifdef SSEG_CAPTURE_DP_EN
      dp_out_d[ref_idx_q] = ~ref_dp_q;
`endif
      seen_nxt[ref_idx_q] = 1'b1;
      if (&seen_nxt) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q     <= '0;
      valid_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
      dp_out_q     <= '0;
`endif
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
`ifdef SSEG_CAPTURE_DP_EN
      dp_out_q     <= dp_out_d;
`endif
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;
`ifdef SSEG_CAPTURE_DP_EN
  assign bus.dp_out     = dp_out_q;
`else
  assign bus.dp_out     = '0;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed scenarios plus random scans, checked against a
// run-length reference model of the display bus.
module tb_sseg_capture;

  localparam int unsigned ND = 4;
  localparam int          SC = 16;
`ifdef SSEG_CAPTURE_DP_EN
  localparam bit DpEn = 1'b1;
`else
  localparam bit DpEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sseg_capture_if #(.NUM_DIGITS(ND)) bus ();

  sseg_capture #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a capture is due two edges after a run of SC identical
  // legal samples completes (one edge for the input register, one for the output).
  typedef struct {
    int         due;
    int         k;
    logic [6:0] seg;
    logic       dp;
  } cap_t;

  logic [6:0]    seg_tab [16];
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_valid, m_err, m_dp, m_seen;
  logic          m_fd;
  int            m_cycle = 0;
  int            run_len = 0;
  int            run_idx;
  logic [6:0]    run_seg;
  logic          run_dp;
  cap_t          m_q [$];

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  function automatic int decode_ref(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic int slot_of(input logic [ND-1:0] a);
    int zeros = 0;
    int idx   = -1;
    for (int i = 0; i < int'(ND); i++) begin
      if (a[i] == 1'b0) begin
        zeros++;
        idx = i;
      end
    end
    return (zeros == 1) ? idx : -1;
  endfunction

  function automatic logic [4*ND-1:0] m_digits();
    logic [4*ND-1:0] r;
    for (int i = 0; i < int'(ND); i++) r[4*i +: 4] = m_dig[i];
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic [ND-1:0] a, input logic [6:0] s,
                            input logic d);
    int   k;
    int   v;
    cap_t c;
    m_cycle++;
    if (r) begin
      for (int i = 0; i < int'(ND); i++) m_dig[i] = 4'h0;
      m_valid = '0;
      m_err   = '0;
      m_dp    = '0;
      m_seen  = '0;
      m_fd    = 1'b0;
      run_len = 0;
      m_q.delete();
      return;
    end
    m_fd = 1'b0;
    while (m_q.size() > 0 && m_q[0].due == m_cycle) begin
      c = m_q.pop_front();
      v = decode_ref(c.seg);
      if (v >= 0) begin
        m_dig[c.k]   = 4'(v);
        m_valid[c.k] = 1'b1;
        m_err[c.k]   = 1'b0;
      end else begin
        m_valid[c.k] = 1'b0;
        m_err[c.k]   = 1'b1;
      end
      if (DpEn) m_dp[c.k] = ~c.dp;
      m_seen[c.k] = 1'b1;
      if (&m_seen) begin
        m_fd   = 1'b1;
        m_seen = '0;
      end
    end
    k = slot_of(a);
    if (k < 0) begin
      run_len = 0;
    end else if (run_len > 0 && k == run_idx && s == run_seg && (!DpEn || d == run_dp)) begin
      run_len++;
    end else begin
      run_len = 1;
      run_idx = k;
      run_seg = s;
      run_dp  = d;
    end
    if (run_len == SC) m_q.push_back('{due: m_cycle + 2, k: run_idx, seg: run_seg, dp: run_dp});
  endtask

  // Drive at the falling edge, let the rising edge register it, observe at the next fall.
  task automatic tick(input logic r, input logic [ND-1:0] a, input logic [6:0] s, input logic d);
    rst      = r;
    bus.an   = a;
    bus.sseg = s;
    bus.dp   = d;
    @(posedge clk);
    model_edge(r, a, s, d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) tick(1'b1, ND'($urandom), 7'($urandom), 1'($urandom));
    n_checks++;
    if (bus.digits !== '0) begin
      n_fail++;
      $display("FAIL reset_digits: got %h expected 0", bus.digits);
    end
    n_checks++;
    if (bus.valid !== '0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    n_checks++;
    if (bus.err !== '0) begin
      n_fail++;
      $display("FAIL reset_err: got %b expected 0", bus.err);
    end
    n_checks++;
    if (bus.dp_out !== '0) begin
      n_fail++;
      $display("FAIL reset_dp_out: got %b expected 0", bus.dp_out);
    end
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, '1, 7'($urandom), 1'($urandom));
      n_checks++;
      if (bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle_frame_done: cycle %0d got %b expected 0", i, bus.frame_done);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 19; i++) tick(1'b0, (i < 15) ? 4'b1110 : 4'hF, 7'h30, 1'b1);
    n_checks++;
    if (bus.valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_15_cycles: valid[0] got %b expected 0", bus.valid[0]);
    end
    for (int i = 0; i < 21; i++) begin
      tick(1'b0, (i < 16) ? 4'b1110 : 4'hF, 7'h30, 1'b1);
      if (i == 16) begin
        n_checks++;
        if (bus.valid[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early: valid[0] got %b expected 0", bus.valid[0]);
        end
      end
      if (i == 17) begin
        n_checks++;
        if (bus.valid[0] !== 1'b1 || bus.digits[3:0] !== 4'h3) begin
          n_fail++;
          $display("FAIL single_capture: valid[0]=%b digit=%h expected 1/3",
                   bus.valid[0], bus.digits[3:0]);
        end
      end
      n_checks++;
      if (bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_no_frame: cycle %0d frame_done got %b expected 0", i, bus.frame_done);
      end
    end
  endtask

  task automatic test_full_frame();
    logic [6:0] pat [4];
    int         pulses = 0;
    pat[0] = 7'h79;
    pat[1] = 7'h08;
    pat[2] = 7'h40;
    pat[3] = 7'h0E;
    for (int scan = 0; scan < 2; scan++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 20; c++) begin
          tick(1'b0, ~(ND'(1) << d), pat[d], 1'b1);
          if (bus.frame_done === 1'b1) pulses++;
          n_checks++;
          if (bus.frame_done !== m_fd) begin
            n_fail++;
            $display("FAIL frame_pulse: scan %0d digit %0d cycle %0d got %b expected %b",
                     scan, d, c, bus.frame_done, m_fd);
          end
        end
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL frame_count: got %0d pulses expected 2", pulses);
    end
    n_checks++;
    if (bus.digits !== 16'hF0A1 || bus.valid !== 4'hF || bus.err !== 4'h0) begin
      n_fail++;
      $display("FAIL frame_values: digits=%h valid=%b err=%b expected F0A1/1111/0000",
               bus.digits, bus.valid, bus.err);
    end
  endtask

  task automatic test_illegal_glitch();
    int first_valid = -1;
    for (int i = 0; i < 20; i++) tick(1'b0, 4'b1011, 7'h7F, 1'b1);
    n_checks++;
    if (bus.err[2] !== 1'b1 || bus.valid[2] !== 1'b0 || bus.digits[11:8] !== 4'h0) begin
      n_fail++;
      $display("FAIL illegal_pattern: err=%b valid=%b digit=%h expected 1/0/0",
               bus.err[2], bus.valid[2], bus.digits[11:8]);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 4'b1011, (i == 10) ? 7'h25 : 7'h24, 1'b1);
      if (bus.valid[2] === 1'b1 && first_valid < 0) first_valid = i;
    end
    n_checks++;
    if (first_valid != 28) begin
      n_fail++;
      $display("FAIL glitch_delay: capture after %0d cycles expected 28", first_valid);
    end
    n_checks++;
    if (bus.digits[11:8] !== 4'h2 || bus.err[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_value: digit=%h err=%b expected 2/0", bus.digits[11:8], bus.err[2]);
    end
  endtask

  task automatic test_multi_low();
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 4'b1100, 7'h00, 1'b1);
      n_checks++;
      if (bus.digits !== m_digits() || bus.valid !== m_valid || bus.frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL multi_low: digits=%h valid=%b fd=%b expected %h/%b/%b",
                 bus.digits, bus.valid, bus.frame_done, m_digits(), m_valid, m_fd);
      end
    end
    n_checks++;
    if (bus.digits !== 16'hF2A1 || bus.valid !== 4'hF) begin
      n_fail++;
      $display("FAIL multi_low_hold: digits=%h valid=%b expected F2A1/1111", bus.digits, bus.valid);
    end
  endtask

  task automatic test_reset_mid_track();
    for (int i = 0; i < 8; i++) tick(1'b0, 4'b1101, 7'h19, 1'b1);
    tick(1'b1, 4'b1101, 7'h19, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, '1, 7'h19, 1'b1);
      n_checks++;
      if (bus.valid !== '0 || bus.err !== '0 || bus.frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_track: cycle %0d valid=%b err=%b fd=%b expected all 0",
                 i, bus.valid, bus.err, bus.frame_done);
      end
    end
    n_checks++;
    if (bus.digits !== '0) begin
      n_fail++;
      $display("FAIL reset_track_digits: got %h expected 0", bus.digits);
    end
  endtask

  task automatic test_dp();
    for (int i = 0; i < 20; i++) tick(1'b0, 4'b1101, 7'h12, 1'b0);
    n_checks++;
    if (bus.valid[1] !== 1'b1 || bus.digits[7:4] !== 4'h5) begin
      n_fail++;
      $display("FAIL dp_digit: valid=%b digit=%h expected 1/5", bus.valid[1], bus.digits[7:4]);
    end
`ifdef SSEG_CAPTURE_DP_EN
    n_checks++;
    if (bus.dp_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL dp_capture: dp_out got %b expected 0010", bus.dp_out);
    end
`else
    n_checks++;
    if (bus.dp_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL dp_disabled: dp_out got %b expected 0000", bus.dp_out);
    end
`endif
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, 4'b0111, 7'h06, 1'((i / 4) % 2));
      if (i == 17) begin
        n_checks++;
        if (bus.valid[3] !== m_valid[3] || bus.dp_out !== m_dp) begin
          n_fail++;
          $display("FAIL dp_toggle_model: valid[3]=%b dp_out=%b expected %b/%b",
                   bus.valid[3], bus.dp_out, m_valid[3], m_dp);
        end
`ifndef SSEG_CAPTURE_DP_EN
        n_checks++;
        if (bus.valid[3] !== 1'b1 || bus.digits[15:12] !== 4'hE) begin
          n_fail++;
          $display("FAIL dp_toggle_capture: valid[3]=%b digit=%h expected 1/E",
                   bus.valid[3], bus.digits[15:12]);
        end
`endif
      end
    end
  endtask

  task automatic test_random();
    logic [ND-1:0] a;
    logic [6:0]    s;
    logic          d;
    bit            tog;
    int            len;
    int            r;
    for (int chunk = 0; chunk < 45; chunk++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = ~(ND'(1) << $urandom_range(0, ND - 1));
      else if (r == 7) a = '1;
      else             a = ND'($urandom);
      s   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      d   = 1'($urandom);
      tog = ($urandom_range(0, 3) == 0);
      len = int'($urandom_range(1, 24));
      if ($urandom_range(0, 19) == 0) tick(1'b1, a, s, d);
      for (int c = 0; c < len; c++) begin
        tick(1'b0, a, s, tog ? 1'((c / 3) % 2) : d);
        n_checks++;
        if ({bus.digits, bus.valid, bus.err, bus.dp_out, bus.frame_done} !==
            {m_digits(), m_valid, m_err, m_dp, m_fd}) begin
          n_fail++;
          $display("FAIL random_outputs: got dig=%h v=%b e=%b dp=%b fd=%b expected dig=%h v=%b e=%b dp=%b fd=%b",
                   bus.digits, bus.valid, bus.err, bus.dp_out, bus.frame_done,
                   m_digits(), m_valid, m_err, m_dp, m_fd);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.an   = '1;
    bus.sseg = '1;
    bus.dp   = 1'b1;
    test_reset();
    test_single();
    test_full_frame();
    test_illegal_glitch();
    test_multi_low();
    test_reset_mid_track();
    test_dp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
